// File: rtl/fork_join_pkg.sv
// Shared types and constants for the fork/join branch scheduler.
package fork_join_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN_PAR = 2'd1,
        RUN_SEQ = 2'd2,
        JOIN    = 2'd3
    } state_t;

    localparam logic MODE_PAR = 1'b0;
    localparam logic MODE_SEQ = 1'b1;

    // Elapsed counter width: wide enough for N_BR back-to-back maximum delays.
    function automatic int calc_ew(input int n_br, input int dw);
        return dw + $clog2(n_br);
    endfunction

endpackage

// File: rtl/fork_join_sched_branch_timer.sv
// One branch: DW-bit down-counter that pulses fire_pulse once when its delay
// elapses, or is retired silently by kill. complete marks either outcome.
module branch_timer #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [DW-1:0] load_val,
    input  logic          enable,
    input  logic          kill,
    output logic          fire_pulse,
    output logic          complete
);

    logic [DW-1:0] cnt;

    // Count down while enabled; kill beats expiry in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            fire_pulse <= 1'b0;
            complete   <= 1'b0;
        end else begin
            fire_pulse <= 1'b0;
            if (load) begin
                // A zero delay behaves like a one-cycle delay.
                cnt      <= (load_val == '0) ? DW'(1) : load_val;
                complete <= 1'b0;
            end else if (!complete) begin
                if (kill) begin
                    complete <= 1'b1;
                end else if (enable) begin
                    if (cnt == DW'(1)) begin
                        fire_pulse <= 1'b1;
                        complete   <= 1'b1;
                    end else begin
                        cnt <= cnt - DW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/fork_join_sched.sv
// Fork/join scheduler: launches N_BR timed branches in parallel or in
// sequence, supports per-branch kill and global abort, reports join.
module fork_join_sched
    import fork_join_pkg::*;
#(
    parameter int N_BR = 4,
    parameter int DW   = 8,
    parameter int EW   = calc_ew(N_BR, DW)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               seq_mode,
    input  logic [N_BR*DW-1:0] delay_i,
    input  logic [N_BR-1:0]    kill_mask,
    input  logic               abort,
    output logic               busy,
    output logic [N_BR-1:0]    fire,
    output logic               done,
    output logic               aborted,
    output logic [EW-1:0]      elapsed
);

    localparam int IW = $clog2(N_BR);

    state_t          state, state_n;
    logic            running, load, all_cmp, done_n, aborted_n;
    logic [N_BR-1:0] complete, br_en, br_kill;
    logic [IW-1:0]   idx;

    assign running = (state == RUN_PAR) || (state == RUN_SEQ);
    assign load    = (state == IDLE) && start;
    assign all_cmp = &complete;

    // Sequential pointer: lowest branch not yet fired or killed, so branches
    // killed ahead of time are skipped without costing a cycle.
    always_comb begin
        idx = '0;
        for (int k = N_BR - 1; k >= 0; k--) begin
            if (!complete[k]) idx = IW'(k);
        end
    end

    for (genvar k = 0; k < N_BR; k++) begin : g_br
        assign br_en[k]   = running && ((state == RUN_PAR) || (idx == IW'(k)));
        // Abort retires every branch so no late fire can escape.
        assign br_kill[k] = running && (kill_mask[k] || abort);

        branch_timer #(.DW(DW)) u_tmr (
            .clk        (clk),
            .rst        (rst),
            .load       (load),
            .load_val   (delay_i[k*DW +: DW]),
            .enable     (br_en[k]),
            .kill       (br_kill[k]),
            .fire_pulse (fire[k]),
            .complete   (complete[k])
        );
    end

    // Next-state and pulse decode; abort takes priority over join.
    always_comb begin
        state_n   = state;
        done_n    = 1'b0;
        aborted_n = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_n = (seq_mode == MODE_SEQ) ? RUN_SEQ : RUN_PAR;
            end
            RUN_PAR, RUN_SEQ: begin
                if (abort) begin
                    state_n   = IDLE;
                    aborted_n = 1'b1;
                end else if (all_cmp) begin
                    state_n = JOIN;
                    done_n  = 1'b1;
                end
            end
            JOIN:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State and registered outputs; elapsed freezes on the join/abort edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            aborted <= 1'b0;
            elapsed <= '0;
        end else begin
            state   <= state_n;
            busy    <= (state_n == RUN_PAR) || (state_n == RUN_SEQ);
            done    <= done_n;
            aborted <= aborted_n;
            if (load) begin
                elapsed <= '0;
            end else if (running && !abort && !all_cmp && (elapsed != '1)) begin
                elapsed <= elapsed + EW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fork_join_sched.sv
// Scoreboard bench: the driver queues expected pulse events (cycle, fire,
// done, aborted, elapsed); a negedge monitor pops one per observed pulse.
module tb_fork_join_sched;

    localparam int N_BR = 4;
    localparam int DW   = 8;
    localparam int EW   = DW + $clog2(N_BR);

    logic               clk = 1'b0;
    logic               rst, start, seq_mode, abort;
    logic [N_BR*DW-1:0] delay_i;
    logic [N_BR-1:0]    kill_mask;
    logic               busy, done, aborted;
    logic [N_BR-1:0]    fire;
    logic [EW-1:0]      elapsed;

    typedef struct {
        int         t;
        logic [3:0] f;
        logic       d;
        logic       a;
        int         el;
    } ev_t;

    ev_t sb[$];
    int  cyc = 0;
    int  n_chk = 0;
    int  n_pass = 0;
    int  t0;

    fork_join_sched #(.N_BR(N_BR), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .seq_mode  (seq_mode),
        .delay_i   (delay_i),
        .kill_mask (kill_mask),
        .abort     (abort),
        .busy      (busy),
        .fire      (fire),
        .done      (done),
        .aborted   (aborted),
        .elapsed   (elapsed)
    );

    always #5 clk = ~clk;

    // Edge counter: after posedge n, cyc == n.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic push(input int t, input logic [3:0] f, input logic d, input logic a, input int el);
        ev_t e;
        e.t = t; e.f = f; e.d = d; e.a = a; e.el = el;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] pk(input int d0, input int d1, input int d2, input int d3);
        return {d3[7:0], d2[7:0], d1[7:0], d0[7:0]};
    endfunction

    // Start is sampled at the next edge, which becomes T0.
    task automatic launch(input logic sm, input logic [31:0] d, input bit hold);
        seq_mode = sm;
        delay_i  = d;
        start    = 1'b1;
        tick();
        t0 = cyc;
        if (!hold) start = 1'b0;
    endtask

    task automatic drain(input string nm, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        if (sb.size() != 0) begin
            n_chk++;
            $display("FAIL %s: timeout, %0d expected events not seen", nm, sb.size());
            sb.delete();
        end
        tick();
    endtask

    // Monitor: every pulse on fire/done/aborted must match the queue head.
    always @(negedge clk) begin
        if (!rst && (|fire || done || aborted)) begin
            n_chk++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_event: t=%0d fire=%b done=%b aborted=%b, none queued",
                         cyc, fire, done, aborted);
            end else begin
                ev_t e;
                e = sb.pop_front();
                if (cyc == e.t && fire === e.f && done === e.d && aborted === e.a &&
                    elapsed === EW'(e.el))
                    n_pass++;
                else
                    $display("FAIL event: got t=%0d fire=%b done=%b ab=%b el=%0d expected t=%0d fire=%b done=%b ab=%b el=%0d",
                             cyc, fire, done, aborted, elapsed, e.t, e.f, e.d, e.a, e.el);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; seq_mode = 1'b0; abort = 1'b0;
        delay_i = '0; kill_mask = '0;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_fire", fire, 0);
        chk("rst_done", done, 0);
        chk("rst_aborted", aborted, 0);
        chk("rst_elapsed", elapsed, 0);
        rst = 1'b0;
        tick();

        // Parallel {3,5,5,9}
        launch(1'b0, pk(3, 5, 5, 9), 0);
        chk("par_busy", busy, 1);
        push(t0+3, 4'b0001, 0, 0, 3);
        push(t0+5, 4'b0110, 0, 0, 5);
        push(t0+9, 4'b1000, 0, 0, 9);
        push(t0+10, 4'b0000, 1, 0, 9);
        drain("par", 30);
        chk("par_idle", busy, 0);
        chk("par_hold_elapsed", elapsed, 9);

        // Sequential {2,4,1,3}
        launch(1'b1, pk(2, 4, 1, 3), 0);
        push(t0+2, 4'b0001, 0, 0, 2);
        push(t0+6, 4'b0010, 0, 0, 6);
        push(t0+7, 4'b0100, 0, 0, 7);
        push(t0+10, 4'b1000, 0, 0, 10);
        push(t0+11, 4'b0000, 1, 0, 10);
        drain("seq", 30);

        // Parallel {4,4,4,12}, branch 3 killed at edge T0+6
        launch(1'b0, pk(4, 4, 4, 12), 0);
        push(t0+4, 4'b0111, 0, 0, 4);
        push(t0+7, 4'b0000, 1, 0, 6);
        repeat (5) tick();
        kill_mask = 4'b1000;
        drain("par_kill", 20);
        kill_mask = '0;

        // Sequential {5,5,5,5}, abort sampled at edge T0+9, relaunch at T0+12
        launch(1'b1, pk(5, 5, 5, 5), 0);
        push(t0+5, 4'b0001, 0, 0, 5);
        push(t0+9, 4'b0000, 0, 1, 8);
        repeat (8) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        repeat (2) tick();
        chk("abort_frozen_elapsed", elapsed, 8);
        launch(1'b0, pk(2, 0, 1, 2), 0);
        chk("relaunch_t0", t0 - cyc, 0);
        chk("relaunch_busy", busy, 1);
        push(t0+1, 4'b0110, 0, 0, 1);
        push(t0+2, 4'b1001, 0, 0, 2);
        push(t0+3, 4'b0000, 1, 0, 2);
        drain("relaunch", 20);

        // All-zero delays in parallel
        launch(1'b0, pk(0, 0, 0, 0), 0);
        push(t0+1, 4'b1111, 0, 0, 1);
        push(t0+2, 4'b0000, 1, 0, 1);
        drain("zero", 20);

        // Start held high while busy: no relaunch
        launch(1'b0, pk(3, 3, 3, 3), 1);
        push(t0+3, 4'b1111, 0, 0, 3);
        push(t0+4, 4'b0000, 1, 0, 3);
        repeat (4) tick();
        start = 1'b0;
        drain("start_held", 20);
        repeat (4) tick();
        chk("start_held_no_relaunch", busy, 0);

        // Sequential skip: branch 1 killed in advance, costs nothing
        kill_mask = 4'b0010;
        launch(1'b1, pk(2, 3, 4, 2), 0);
        push(t0+2, 4'b0001, 0, 0, 2);
        push(t0+6, 4'b0100, 0, 0, 6);
        push(t0+8, 4'b1000, 0, 0, 8);
        push(t0+9, 4'b0000, 1, 0, 8);
        drain("seq_skip", 30);
        kill_mask = '0;

        // Kill/expiry collision: branch 1 delay 6, kill sampled at edge T0+6
        launch(1'b0, pk(1, 6, 2, 3), 0);
        push(t0+1, 4'b0001, 0, 0, 1);
        push(t0+2, 4'b0100, 0, 0, 2);
        push(t0+3, 4'b1000, 0, 0, 3);
        push(t0+7, 4'b0000, 1, 0, 6);
        repeat (5) tick();
        kill_mask = 4'b0010;
        drain("collision", 20);
        kill_mask = '0;

        // Reset mid-run at edge T0+3: everything clears, no pulses
        launch(1'b0, pk(5, 5, 5, 5), 0);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        chk("midrst_busy", busy, 0);
        chk("midrst_fire", fire, 0);
        chk("midrst_done", done, 0);
        chk("midrst_aborted", aborted, 0);
        chk("midrst_elapsed", elapsed, 0);
        rst = 1'b0;
        repeat (8) tick();
        chk("midrst_idle", busy, 0);

        // Anything still queued was never observed.
        n_chk++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL leftover_events: got %0d pending expected 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
